// File: rtl/shift_right_sequencer_pkg.sv
// Shared defaults and FSM state encoding for the shift-right sequencer.
package shift_right_sequencer_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_right_sequencer_stage.sv
// One-position right shift with an explicit fill bit for the vacated MSB.
module shift_right_stage #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = {fill_i, data_i[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_sequencer.sv
// Multi-cycle right shifter: one bit per clock, N shifts per operation.
// Define SHIFT_ARITH_EN to add the arith port (sign fill); default is logical.
module shift_right_sequencer
    import shift_right_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [CNT_W-1:0] N,
`ifdef SHIFT_ARITH_EN
    input  logic             arith,
`endif
    output logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] shifted;
    logic             fill_in;

`ifdef SHIFT_ARITH_EN
    assign fill_in = arith & A[WIDTH-1];
`else
    assign fill_in = 1'b0;
`endif

    shift_right_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .data_i (work_q),
        .fill_i (fill_q),
        .data_o (shifted)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = A;
                    cnt_d  = N;
                    fill_d = fill_in;
                    if (N == '0) begin
                        state_d = DONE;
                        y_d     = A;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - CNT_W'(1);
                // Last shift lands directly in Y as we enter DONE
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    y_d     = shifted;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
        end
    end

    assign Y    = y_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Directed and randomized checks of shift_right_sequencer against a shift model.
module tb_shift_right_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] A;
    logic [2:0] N;
`ifdef SHIFT_ARITH_EN
    logic       arith;
`endif
    logic [5:0] Y;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    logic [5:0] prev_y;

    shift_right_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .N     (N),
`ifdef SHIFT_ARITH_EN
        .arith (arith),
`endif
        .Y     (Y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ref_shift(logic [5:0] a, int n, logic ar);
        logic signed [5:0] s;
        s = a;
        if (ar) return 6'(s >>> n);
        return a >> n;
    endfunction

    task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_arith(logic ar);
`ifdef SHIFT_ARITH_EN
        arith = ar;
`else
        if (ar) begin end
`endif
    endtask

    // Full operation; inputs change and outputs are sampled on negedges.
    task automatic do_op(logic [5:0] a, int n, logic ar, string tag);
        logic [5:0] exp;
        logic       eff_ar;
`ifdef SHIFT_ARITH_EN
        eff_ar = ar;
`else
        eff_ar = 1'b0;
`endif
        exp = ref_shift(a, n, eff_ar);
        start = 1'b1;
        A = a;
        N = 3'(n);
        set_arith(ar);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            start = 1'($urandom_range(0, 1));
            A = 6'($urandom);
            N = 3'($urandom);
            set_arith(1'($urandom));
            chk({tag, "_busy"}, {5'b0, busy}, 6'd1);
            chk({tag, "_nodone"}, {5'b0, done}, 6'd0);
            chk({tag, "_yhold"}, Y, prev_y);
            @(negedge clk);
        end
        start = 1'($urandom_range(0, 1));
        chk({tag, "_done"}, {5'b0, done}, 6'd1);
        chk({tag, "_dbusy"}, {5'b0, busy}, 6'd0);
        chk({tag, "_y"}, Y, exp);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_idle_done"}, {5'b0, done}, 6'd0);
        chk({tag, "_idle_busy"}, {5'b0, busy}, 6'd0);
        chk({tag, "_idle_y"}, Y, exp);
        prev_y = exp;
    endtask

    initial begin
        logic [5:0] ra;
        int         rn;
        logic       rar;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        N = '0;
        set_arith(1'b0);
        prev_y = '0;
        repeat (2) @(negedge clk);
        chk("rst_y", Y, 6'd0);
        chk("rst_busy", {5'b0, busy}, 6'd0);
        chk("rst_done", {5'b0, done}, 6'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(6'b101101, 2, 1'b0, "n2");
        do_op(6'b111111, 0, 1'b0, "n0");
        do_op(6'b100000, 7, 1'b0, "n7_log");
        do_op(6'b100000, 7, 1'b1, "n7_ar");
        do_op(6'b011011, 6, 1'b1, "n6_pos");

        // start held high: accept, SHIFT, DONE repeating every 3 cycles
        start = 1'b1;
        A = 6'b000110;
        N = 3'd1;
        set_arith(1'b0);
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            chk("held_busy", {5'b0, busy}, {5'b0, (k % 3) == 0});
            chk("held_done", {5'b0, done}, {5'b0, (k % 3) == 1});
            chk("held_y", Y, (k >= 1) ? 6'b000011 : prev_y);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        prev_y = 6'b000011;

        // reset mid-operation
        start = 1'b1;
        A = 6'b110000;
        N = 3'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_y", Y, 6'd0);
        chk("abort_busy", {5'b0, busy}, 6'd0);
        chk("abort_done", {5'b0, done}, 6'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_nodone", {5'b0, done}, 6'd0);
            chk("abort_idle", {5'b0, busy}, 6'd0);
        end
        prev_y = '0;

        do_op(6'b010100, 1, 1'b0, "b2b_a");
        do_op(6'b000011, 1, 1'b0, "b2b_b");

        for (int i = 0; i < 25; i++) begin
            ra  = 6'($urandom);
            rn  = int'($urandom_range(0, 7));
            rar = 1'($urandom);
            do_op(ra, rn, rar, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
